// File: rtl/stack_burst_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : stack_burst_buffer_if
// Description : Bus bundle for stack_burst_buffer. It carries the upstream
//               capture port, the downstream drain port and the status flags.
//               slave  : the buffer side (takes Din/i_valid/mode/busy, drives
//                        Dout/o_valid/last and status)
//               master : the environment side (the same signals in the other
//                        direction)
// Revision    : 1.0 - initial release
// ============================================================================
interface stack_burst_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic              mode;
    logic [DATA_W-1:0] Din;
    logic              i_valid;
    logic              busy;
    logic [DATA_W-1:0] Dout;
    logic              o_valid;
    logic              last;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;

    modport slave (
        input  mode, Din, i_valid, busy,
        output Dout, o_valid, last, count, full, empty, overflow
    );

    modport master (
        output mode, Din, i_valid, busy,
        input  Dout, o_valid, last, count, full, empty, overflow
    );
endinterface
`default_nettype wire

// File: rtl/stack_burst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stack_burst_buffer
// Description : Captures a burst of words into a register array, then replays
//               it in reverse (LIFO) or original (FIFO) order, one word per
//               cycle while busy is low.
//               clk   : rising-edge clock
//               reset : synchronous, active-low
//               bus   : stack_burst_buffer_if.slave
//                       in : mode, Din, i_valid, busy
//                       out: Dout, o_valid, last, count, full, empty, overflow
// Revision    : 1.0 - initial release
// ============================================================================
module stack_burst_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    stack_burst_buffer_if.slave   bus
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] rd_ptr;
    logic              mode_q;
    logic [DATA_W-1:0] dout_q;
    logic              o_valid_q;
    logic              last_q;
    logic              overflow_q;

    logic              start;
    logic              wr_en;
    logic              drop;
    logic              issue;
    logic              is_full;
    logic              final_word;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;

    assign is_full    = (count_q == FULL_COUNT);
    assign final_word = (count_q == ONE_COUNT);

    // Every burst fills from entry 0, so the write index is simply count.
    assign wr_idx = start ? '0 : ADDR_W'(count_q);
    // LIFO pops the top entry; FIFO walks up from entry 0.
    assign rd_idx = mode_q ? rd_ptr : ADDR_W'(count_q - ONE_COUNT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        wr_en      = 1'b0;
        drop       = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    start      = 1'b1;
                    wr_en      = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (bus.i_valid) begin
                    if (is_full) begin
                        drop = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end else if (!bus.busy) begin
                    issue      = 1'b1;
                    next_state = final_word ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                drop = bus.i_valid;
                if (!bus.busy) begin
                    issue = 1'b1;
                    if (final_word) begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Array contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[wr_idx] <= bus.Din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q    <= '0;
            rd_ptr     <= '0;
            mode_q     <= 1'b0;
            dout_q     <= '0;
            o_valid_q  <= 1'b0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // Writes and issues never coincide, so one priority chain suffices.
            if (start) begin
                count_q    <= ONE_COUNT;
                mode_q     <= bus.mode;
                rd_ptr     <= '0;
                overflow_q <= 1'b0;
            end else if (wr_en) begin
                count_q <= count_q + ONE_COUNT;
            end else if (issue) begin
                count_q <= count_q - ONE_COUNT;
                rd_ptr  <= final_word ? '0 : rd_ptr + 1'b1;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end

            dout_q    <= issue ? mem[rd_idx] : '0;
            o_valid_q <= issue;
            last_q    <= issue && final_word;
        end
    end

    assign bus.Dout     = dout_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.last     = last_q;
    assign bus.count    = count_q;
    assign bus.full     = is_full;
    assign bus.empty    = (count_q == '0);
    assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_burst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_burst_buffer
// Description : Self-checking bench for stack_burst_buffer. Expected output
//               words are queued as each burst is driven and consumed by a
//               monitor on the falling edge; scenario tasks check status and
//               timing inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_burst_buffer;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    // {last, data}
    logic [8:0] exp_q [$];

    stack_burst_buffer_if #(.DATA_W(8), .DEPTH(16)) bus ();

    stack_burst_buffer #(.DATA_W(8), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every issued word must match the head of the queue;
    // idle cycles must show zero data and no last marker.
    always @(negedge clk) begin
        logic [8:0] e;
        total++;
        if (bus.o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_word: got Dout=%h last=%b, expected no word", bus.Dout, bus.last);
            end else begin
                e = exp_q.pop_front();
                if ({bus.last, bus.Dout} !== e)
                    $display("FAIL drain_word: got last=%b Dout=%h, expected last=%b Dout=%h",
                             bus.last, bus.Dout, e[8], e[7:0]);
                else
                    passed++;
            end
        end else begin
            if (bus.Dout !== 8'h00 || bus.last !== 1'b0 || bus.o_valid !== 1'b0)
                $display("FAIL idle_outputs: got o_valid=%b Dout=%h last=%b, expected 0/00/0",
                         bus.o_valid, bus.Dout, bus.last);
            else
                passed++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; bus.i_valid = 1'b0; bus.busy = 1'b0; bus.mode = 1'b0; bus.Din = 8'h00;
        tick; tick;
        total++; if (bus.Dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", bus.Dout); else passed++;
        total++; if (bus.o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b expected 0", bus.o_valid); else passed++;
        total++; if (bus.last !== 1'b0) $display("FAIL reset_last: got %b expected 0", bus.last); else passed++;
        total++; if (bus.count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", bus.count); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", bus.overflow); else passed++;
        total++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b expected 0", bus.full); else passed++;
        total++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", bus.empty); else passed++;
        reset = 1'b1;
        tick;
    endtask

    task automatic test_lifo;
        logic [7:0] w [4];
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        bus.mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.Din = w[i]; bus.i_valid = 1'b1;
            tick;
        end
        total++; if (bus.count !== 5'd4) $display("FAIL lifo_count: got %0d expected 4", bus.count); else passed++;
        bus.i_valid = 1'b0;
        for (int i = 3; i >= 0; i--) exp_q.push_back({(i == 0), w[i]});
        for (int k = 0; k < 4; k++) begin
            tick;
            total++; if (bus.o_valid !== 1'b1) $display("FAIL lifo_consecutive: cycle %0d got o_valid=%b expected 1", k, bus.o_valid); else passed++;
        end
        tick;
        total++; if (bus.o_valid !== 1'b0) $display("FAIL lifo_end: got o_valid=%b expected 0", bus.o_valid); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL lifo_all_words: got %0d left expected 0", exp_q.size()); else passed++;
        total++; if (bus.count !== 5'd0) $display("FAIL lifo_count_after: got %0d expected 0", bus.count); else passed++;
        total++; if (bus.empty !== 1'b1) $display("FAIL lifo_empty_after: got %b expected 1", bus.empty); else passed++;
    endtask

    task automatic test_fifo;
        logic [7:0] w [4];
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            // mode is 1 on the first word, then toggles and must be ignored
            bus.mode = (i % 2 == 0); bus.Din = w[i]; bus.i_valid = 1'b1;
            tick;
        end
        bus.i_valid = 1'b0; bus.mode = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), w[i]});
        for (int k = 0; k < 4; k++) begin
            tick;
            total++; if (bus.o_valid !== 1'b1) $display("FAIL fifo_consecutive: cycle %0d got o_valid=%b expected 1", k, bus.o_valid); else passed++;
        end
        tick;
        total++; if (exp_q.size() != 0) $display("FAIL fifo_all_words: got %0d left expected 0", exp_q.size()); else passed++;
        total++; if (bus.empty !== 1'b1) $display("FAIL fifo_empty_after: got %b expected 1", bus.empty); else passed++;
    endtask

    task automatic test_overflow;
        bus.mode = 1'b0;
        for (int i = 0; i < 18; i++) begin
            bus.Din = 8'(i); bus.i_valid = 1'b1;
            tick;
            if (i == 14) begin
                total++; if (bus.full !== 1'b0) $display("FAIL ovf_not_full_15: got %b expected 0", bus.full); else passed++;
            end
            if (i == 15) begin
                total++; if (bus.full !== 1'b1) $display("FAIL ovf_full_16: got %b expected 1", bus.full); else passed++;
                total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_not_yet: got %b expected 0", bus.overflow); else passed++;
            end
            if (i == 16) begin
                total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set_17: got %b expected 1", bus.overflow); else passed++;
                total++; if (bus.count !== 5'd16) $display("FAIL ovf_count_held: got %0d expected 16", bus.count); else passed++;
            end
        end
        bus.i_valid = 1'b0;
        for (int i = 15; i >= 0; i--) exp_q.push_back({(i == 0), 8'(i)});
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick;
        total++; if (exp_q.size() != 0) $display("FAIL ovf_drain_timeout: got %0d left expected 0", exp_q.size()); else passed++;
        tick;
        total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); else passed++;
        total++; if (bus.empty !== 1'b1) $display("FAIL ovf_empty_after: got %b expected 1", bus.empty); else passed++;
    endtask

    task automatic test_stall;
        logic [7:0] w [4];
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        bus.mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.Din = w[i]; bus.i_valid = 1'b1;
            tick;
            if (i == 0) begin
                total++; if (bus.overflow !== 1'b0) $display("FAIL overflow_clear: got %b expected 0", bus.overflow); else passed++;
            end
        end
        bus.i_valid = 1'b0; bus.busy = 1'b0;
        for (int i = 3; i >= 0; i--) exp_q.push_back({(i == 0), w[i]});
        tick;
        total++; if (bus.o_valid !== 1'b1) $display("FAIL stall_first: got o_valid=%b expected 1", bus.o_valid); else passed++;
        bus.busy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            total++; if (bus.o_valid !== 1'b0) $display("FAIL stall_o_valid: cycle %0d got %b expected 0", k, bus.o_valid); else passed++;
            total++; if (bus.Dout !== 8'h00) $display("FAIL stall_dout: cycle %0d got %h expected 00", k, bus.Dout); else passed++;
        end
        bus.busy = 1'b0;
        tick;
        total++; if (bus.o_valid !== 1'b1) $display("FAIL stall_resume: got o_valid=%b expected 1", bus.o_valid); else passed++;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick;
        total++; if (exp_q.size() != 0) $display("FAIL stall_drain_timeout: got %0d left expected 0", exp_q.size()); else passed++;
        tick;
        total++; if (bus.count !== 5'd0) $display("FAIL stall_count_after: got %0d expected 0", bus.count); else passed++;
    endtask

    task automatic test_mid_reset;
        logic [7:0] w [4];
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        bus.mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.Din = w[i]; bus.i_valid = 1'b1;
            tick;
        end
        bus.i_valid = 1'b0;
        for (int i = 3; i >= 0; i--) exp_q.push_back({(i == 0), w[i]});
        tick;
        // word presented during DRAIN is dropped and flags overflow
        bus.Din = 8'hEE; bus.i_valid = 1'b1;
        tick;
        total++; if (bus.overflow !== 1'b1) $display("FAIL drain_drop_overflow: got %b expected 1", bus.overflow); else passed++;
        bus.i_valid = 1'b0; reset = 1'b0;
        tick;
        total++; if (bus.o_valid !== 1'b0) $display("FAIL mreset_o_valid: got %b expected 0", bus.o_valid); else passed++;
        total++; if (bus.count !== 5'd0) $display("FAIL mreset_count: got %0d expected 0", bus.count); else passed++;
        total++; if (bus.empty !== 1'b1) $display("FAIL mreset_empty: got %b expected 1", bus.empty); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL mreset_overflow: got %b expected 0", bus.overflow); else passed++;
        total++; if (exp_q.size() != 2) $display("FAIL mreset_drained: got %0d left expected 2", exp_q.size()); else passed++;
        exp_q.delete();
        reset = 1'b1;
        bus.Din = 8'h5A; bus.i_valid = 1'b1;
        tick;
        bus.i_valid = 1'b0;
        exp_q.push_back({1'b1, 8'h5A});
        tick;
        total++; if (bus.o_valid !== 1'b1) $display("FAIL single_o_valid: got %b expected 1", bus.o_valid); else passed++;
        total++; if (bus.last !== 1'b1) $display("FAIL single_last: got %b expected 1", bus.last); else passed++;
        tick;
        total++; if (bus.o_valid !== 1'b0) $display("FAIL single_only_one: got %b expected 0", bus.o_valid); else passed++;
        total++; if (bus.count !== 5'd0) $display("FAIL single_count: got %0d expected 0", bus.count); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL single_consumed: got %0d left expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_busy_hold;
        logic [7:0] w [3];
        w[0] = 8'hA1; w[1] = 8'hA2; w[2] = 8'hA3;
        bus.mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.Din = w[i]; bus.i_valid = 1'b1;
            tick;
        end
        bus.i_valid = 1'b0; bus.busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            total++; if (bus.o_valid !== 1'b0) $display("FAIL hold_o_valid: cycle %0d got %b expected 0", k, bus.o_valid); else passed++;
            total++; if (bus.count !== 5'd3) $display("FAIL hold_count: cycle %0d got %0d expected 3", k, bus.count); else passed++;
        end
        for (int i = 2; i >= 0; i--) exp_q.push_back({(i == 0), w[i]});
        bus.busy = 1'b0;
        tick;
        total++; if (bus.o_valid !== 1'b1) $display("FAIL hold_release: got o_valid=%b expected 1", bus.o_valid); else passed++;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick;
        total++; if (exp_q.size() != 0) $display("FAIL hold_drain_timeout: got %0d left expected 0", exp_q.size()); else passed++;
        tick;
        total++; if (bus.empty !== 1'b1) $display("FAIL hold_empty_after: got %b expected 1", bus.empty); else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset;
        test_lifo;
        test_fifo;
        test_overflow;
        test_stall;
        test_mid_reset;
        test_busy_hold;
        tick; tick;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_burst_buffer.md
# stack_burst_buffer

Parametrised burst buffer: it captures a burst of words from an upstream source, then replays the burst to a downstream consumer. Replay is in reverse order (LIFO) or original order (FIFO), selected per burst. It is the successor to the fixed 8-bit, 16-entry reversal buffer. It adds:
- configurable width and depth,
- a FIFO mode,
- full/empty/count status,
- overflow detection,
- a last-word marker,
- per-word back-pressure from `busy`.

Storage is an internal register array with no tristate data path.

## Interface
- `DATA_W`, default 8: data word width in bits.
- `DEPTH`, default 16: number of entries; any value ≥ 2.
- `ADDR_W`, default `$clog2(DEPTH)`: index width; not overridden by users.

- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-low. `reset==0` at a rising edge clears all state.
- `mode`  in  1: 0 = LIFO, 1 = FIFO. Latched on the first accepted word of a burst and ignored otherwise.
- `Din`  in  DATA_W: input word.
- `i_valid`  in  1: `Din` valid this cycle.
- `busy`  in  1: downstream cannot take a word this cycle.
- `Dout`  out  DATA_W: registered output word; 0 whenever `o_valid==0`.
- `o_valid`  out  1: registered; one-cycle pulse per issued word.
- `last`  out  1: registered; high with the final word of a drain.
- `count`  out  ADDR_W+1: number of words stored.
- `full`  out  1: `count==DEPTH`, combinational from `count`.
- `empty`  out  1: `count==0`, combinational from `count`.
- `overflow`  out  1: sticky flag, set when an input word is dropped.

## Operation
- States: IDLE, LOAD, DRAIN. Each burst starts from an empty array, so pointers never wrap.
- IDLE:
  - `i_valid=1`: write `Din` to entry 0, `count<=1`, latch `mode`, clear `overflow`, go to LOAD.
  - Otherwise: hold.
- LOAD:
  - `i_valid=1` and not full: write to entry `count`, `count<=count+1`.
  - `i_valid=1` and full: word dropped, `overflow<=1`, `count` unchanged.
  - `i_valid=0`, `busy=1`: wait in LOAD.
  - `i_valid=0`, `busy=0`: issue the first word in this cycle and enter DRAIN. If `count` was 1, go straight to IDLE with `last=1`.
- DRAIN:
  - `busy=0`: issue the next word.
  - `busy=1`: issue nothing; `o_valid<=0`, `Dout<=0`, `last<=0`.
  - `i_valid=1`: the word is dropped and `overflow<=1`.
- Issue, which happens in the same edge for every issued word:
  - `Dout<=mem[idx]`, `o_valid<=1`, `count<=count-1`.
  - `last<=1` iff `count==1`; after that word the state goes to IDLE.
- Read index:
  - LIFO: `idx = count-1`.
  - FIFO: `idx = rd_ptr`. `rd_ptr` starts at 0 and increments per issued word.
- When no word is issued, `o_valid`, `last` and `Dout` are 0 the next cycle.
- The consumer must accept every `o_valid` pulse. `busy` only gates issue of the next word.
- `overflow` is cleared only by reset or by the first word of the next burst.

## Timing
- Reset values:
  - `Dout=0`, `o_valid=0`, `last=0`, `count=0`, `overflow=0`.
  - `full=0`, `empty=1`.
  - State IDLE, `rd_ptr=0`.
- Array contents are don't-care after reset.
- Write latency: a word presented at edge N is counted in `count` after edge N.
- Drain latency: at the first edge where the state is LOAD, `i_valid=0` and `busy=0`, `o_valid=1` is set after that edge. That is one cycle after `i_valid` falls when `busy` is low.
- Throughput:
  - Capture: one word per cycle.
  - Drain: one word per cycle while `busy=0`.
  - Per-word latency from `busy` falling to `o_valid` rising: 1 cycle.
- A burst of N words, drained without stalls, gives N consecutive `o_valid` cycles. `last` is set on the Nth.
- Reset mid-LOAD or mid-DRAIN takes effect at that edge:
  - Outputs return to reset values the next cycle.
  - No partial word is emitted.
- `i_valid` held high with `full=1` never modifies the array.

## Test plan
- LIFO (`mode=0`), `busy=0`, write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> `Dout` = 0x44, 0x33, 0x22, 0x11 on 4 consecutive cycles, starting 1 cycle after `i_valid` falls. `last=1` only with 0x11. Afterwards `count=0`, `empty=1`.
- FIFO (`mode=1`), same burst -> `Dout` = 0x11, 0x22, 0x33, 0x44, `last` with 0x44. `mode` toggled mid-burst has no effect.
- `DEPTH=16`, write 18 words 0x00–0x11 in LIFO -> `full=1` after the 16th word, `overflow=1` after the 17th. Drain gives 0x0F down to 0x00, with no 0x10 or 0x11. `overflow` stays 1 until the next burst's first word.
- LIFO 4-word burst with `busy=1` for drain cycles 2 and 3 -> `o_valid=0` and `Dout=0` during the stall. Order stays 0x44, 0x33, 0x22, 0x11, with no loss or duplication.
- `reset=0` for one edge after 2 of 4 words have drained -> next cycle `o_valid=0`, `count=0`, `empty=1`, `overflow=0`. A following 1-word burst of 0x5A drains as a single `o_valid` with `last=1`.
- `busy=1` held when `i_valid` falls after 3 words -> the block stays in LOAD with `count=3` and `o_valid=0`. The first word appears 1 cycle after `busy` falls.
